// File: rtl/matrix_mul_ctrl_pkg.sv
// Shared opcode offsets, FSM encoding and opcode helper for the matrix-multiply
// controller.
package matrix_mul_pkg;

   localparam logic [7:0] OFS_START = 8'd0;
   localparam logic [7:0] OFS_NEXT  = 8'd1;
   localparam logic [7:0] OFS_END   = 8'd2;
   localparam logic [7:0] OFS_RESET = 8'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_END = 2'd2,
      DRAIN    = 2'd3
   } state_e;

   function automatic logic [7:0] opcode(input int base, input logic [7:0] ofs);
      return 8'(base) + ofs;
   endfunction

endpackage

// File: rtl/matrix_mul_ctrl_if.sv
// Handshake bundle between the controller, its command/operand source,
// the multiply-accumulate unit and the result sink.
interface matrix_mul_ctrl_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_k;
   logic [7:0]  cmd_cnt;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ci_start;
   logic [7:0]  ci_n;
   logic [31:0] ci_dataa;
   logic [31:0] ci_datab;
   logic [31:0] ci_result;
   logic        ci_done;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        busy;
   logic        err;

   modport slave (
      input  cmd_valid, cmd_k, cmd_cnt, op_valid, op_a, op_b,
             ci_result, ci_done, res_ready,
      output cmd_ready, op_ready, ci_start, ci_n, ci_dataa, ci_datab,
             res_valid, res_data, busy, err
   );

   modport master (
      output cmd_valid, cmd_k, cmd_cnt, op_valid, op_a, op_b,
             ci_result, ci_done, res_ready,
      input  cmd_ready, op_ready, ci_start, ci_n, ci_dataa, ci_datab,
             res_valid, res_data, busy, err
   );

endinterface

// File: rtl/matrix_mul_ctrl_wdog.sv
// Watchdog counting cycles spent waiting for the accumulator's END result;
// expired fires on the TIMEOUT-th enabled cycle.
module matrix_mul_ctrl_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count_q, count_d;

   assign expired = enable && (count_q == 8'(TIMEOUT - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable && !expired) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/matrix_mul_ctrl.sv
// Sequences operand pairs into a multiply-accumulate unit as dot products,
// collects results with END and streams them out, bounded by OUTSTANDING.
module matrix_mul_ctrl
   import matrix_mul_pkg::*;
#(
   parameter int N_OFFSET    = 0,
   parameter int OUTSTANDING = 4,
   parameter int TIMEOUT     = 255
) (
   input logic              clk,
   input logic              reset_n,
   matrix_mul_ctrl_if.slave bus
);

   localparam logic [3:0] MAX_PENDING = 4'(OUTSTANDING);
   localparam logic [7:0] OPC_START   = opcode(N_OFFSET, OFS_START);
   localparam logic [7:0] OPC_NEXT    = opcode(N_OFFSET, OFS_NEXT);
   localparam logic [7:0] OPC_END     = opcode(N_OFFSET, OFS_END);
   localparam logic [7:0] OPC_RESET   = opcode(N_OFFSET, OFS_RESET);

   state_e      state_q, state_d;
   logic [7:0]  k_q, k_d, cnt_q, cnt_d, elem_q, elem_d, dot_q, dot_d;
   logic [3:0]  pending_q, pending_d;
   logic        allIssued_q, allIssued_d;
   logic        ciStart_q, ciStart_d;
   logic [7:0]  ciN_q, ciN_d;
   logic [31:0] ciA_q, ciA_d, ciB_q, ciB_d;
   logic        resValid_q, resValid_d;
   logic [31:0] resData_q, resData_d;
   logic        err_q, err_d;

   logic cmdFire, opFire, badCmd, lastElem, lastDot, pendingFull;
   logic collectDue, wdogExpired;

   assign cmdFire     = bus.cmd_valid && bus.cmd_ready;
   assign opFire      = bus.op_valid && bus.op_ready;
   assign badCmd      = (bus.cmd_k == 8'd0) || (bus.cmd_cnt == 8'd0);
   assign lastElem    = elem_q == (k_q - 8'd1);
   assign lastDot     = dot_q == (cnt_q - 8'd1);
   assign pendingFull = pending_q == MAX_PENDING;
   assign collectDue  = (pending_q != 4'd0) && !resValid_q &&
                        (((state_q == ISSUE) && (elem_q == 8'd0) && pendingFull) ||
                         (state_q == DRAIN));

   matrix_mul_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_q != WAIT_END),
      .enable  (state_q == WAIT_END),
      .expired (wdogExpired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         k_q         <= 8'd0;
         cnt_q       <= 8'd0;
         elem_q      <= 8'd0;
         dot_q       <= 8'd0;
         pending_q   <= 4'd0;
         allIssued_q <= 1'b0;
         ciStart_q   <= 1'b0;
         ciN_q       <= 8'd0;
         ciA_q       <= 32'd0;
         ciB_q       <= 32'd0;
         resValid_q  <= 1'b0;
         resData_q   <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         elem_q      <= elem_d;
         dot_q       <= dot_d;
         pending_q   <= pending_d;
         allIssued_q <= allIssued_d;
         ciStart_q   <= ciStart_d;
         ciN_q       <= ciN_d;
         ciA_q       <= ciA_d;
         ciB_q       <= ciB_d;
         resValid_q  <= resValid_d;
         resData_q   <= resData_d;
         err_q       <= err_d;
      end
   end

   // A returning result takes precedence over a watchdog expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cmdFire && !badCmd) state_d = ISSUE;
         ISSUE: begin
            if (collectDue)                           state_d = WAIT_END;
            else if (opFire && lastElem && lastDot)   state_d = DRAIN;
         end
         WAIT_END: begin
            if (bus.ci_done)       state_d = allIssued_q ? DRAIN : ISSUE;
            else if (wdogExpired)  state_d = IDLE;
         end
         DRAIN: begin
            if (collectDue)                               state_d = WAIT_END;
            else if ((pending_q == 4'd0) && !resValid_q)  state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      k_d         = k_q;
      cnt_d       = cnt_q;
      elem_d      = elem_q;
      dot_d       = dot_q;
      pending_d   = pending_q;
      allIssued_d = allIssued_q;
      ciStart_d   = 1'b0;
      ciN_d       = 8'd0;
      ciA_d       = 32'd0;
      ciB_d       = 32'd0;
      resValid_d  = resValid_q && !bus.res_ready;
      resData_d   = resData_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (cmdFire) begin
               err_d       = badCmd;
               k_d         = bus.cmd_k;
               cnt_d       = bus.cmd_cnt;
               elem_d      = 8'd0;
               dot_d       = 8'd0;
               pending_d   = 4'd0;
               allIssued_d = 1'b0;
            end
         end
         ISSUE, DRAIN: begin
            if (collectDue) begin
               ciStart_d = 1'b1;
               ciN_d     = OPC_END;
            end else if (opFire) begin
               ciStart_d = 1'b1;
               ciN_d     = (elem_q == 8'd0) ? OPC_START : OPC_NEXT;
               ciA_d     = bus.op_a;
               ciB_d     = bus.op_b;
               if (lastElem) begin
                  elem_d    = 8'd0;
                  pending_d = pending_q + 4'd1;
                  if (lastDot) begin
                     allIssued_d = 1'b1;
                     dot_d       = 8'd0;
                  end else begin
                     dot_d = dot_q + 8'd1;
                  end
               end else begin
                  elem_d = elem_q + 8'd1;
               end
            end
         end
         WAIT_END: begin
            if (bus.ci_done) begin
               resData_d  = bus.ci_result;
               resValid_d = 1'b1;
               pending_d  = pending_q - 4'd1;
            end else if (wdogExpired) begin
               ciStart_d   = 1'b1;
               ciN_d       = OPC_RESET;
               err_d       = 1'b1;
               pending_d   = 4'd0;
               elem_d      = 8'd0;
               dot_d       = 8'd0;
               allIssued_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Issue is also held off while the accumulator slots are full, so that a
   // one-element dot product cannot push pending past OUTSTANDING.
   always_comb begin
      bus.cmd_ready = reset_n && (state_q == IDLE);
      bus.op_ready  = (state_q == ISSUE) && !collectDue &&
                      !((elem_q == 8'd0) && pendingFull);
      bus.busy      = state_q != IDLE;
      bus.ci_start  = ciStart_q;
      bus.ci_n      = ciN_q;
      bus.ci_dataa  = ciA_q;
      bus.ci_datab  = ciB_q;
      bus.res_valid = resValid_q;
      bus.res_data  = resData_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// Self-checking bench: behavioural accumulator model plus a result scoreboard
// filled as operands are driven and drained as results leave the controller.
module tb_matrix_mul_ctrl;

   localparam int NOFF = 8;
   localparam int OUTS = 4;
   localparam int TMO  = 255;
   localparam logic [7:0] OP_START = 8'd8;
   localparam logic [7:0] OP_NEXT  = 8'd9;
   localparam logic [7:0] OP_END   = 8'd10;
   localparam logic [7:0] OP_RESET = 8'd11;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   matrix_mul_ctrl_if bus ();

   matrix_mul_ctrl #(.N_OFFSET(NOFF), .OUTSTANDING(OUTS), .TIMEOUT(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   logic [31:0] expQ[$];
   logic [63:0] opQ[$];
   logic [31:0] macQ[$];
   logic [7:0]  opLog[$];
   logic [31:0] acc = 32'd0;
   logic [31:0] doneVal = 32'd0;
   int curK = 1, macElems = 0, macMax = 0, doneCnt = 0;
   int startCnt = 0, endCnt = 0, resetCnt = 0, endCyc = 0, resetCyc = 0;
   int startsBeforeFirstEnd = 0, resCnt = 0;
   bit suppressDone = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   // Accumulator model: answers END with the oldest completed dot product.
   initial begin
      logic [63:0] pair;
      logic [31:0] prod;
      bus.ci_done   = 1'b0;
      bus.ci_result = 32'd0;
      forever begin
         @(negedge clk);
         bus.ci_done = 1'b0;
         if (doneCnt > 0) begin
            doneCnt--;
            if (doneCnt == 0) begin
               bus.ci_done   = 1'b1;
               bus.ci_result = doneVal;
            end
         end
         if (bus.ci_start) begin
            opLog.push_back(bus.ci_n);
            if (bus.ci_n == OP_START || bus.ci_n == OP_NEXT) begin
               checkOutput("ci_n", 32'(bus.ci_n), (macElems == 0) ? 32'(OP_START) : 32'(OP_NEXT));
               if (bus.ci_n == OP_START) startCnt++;
               if (opQ.size() == 0) begin
                  checkOutput("unexpected operand issue", 32'd0, 32'd1);
               end else begin
                  pair = opQ.pop_front();
                  checkOutput("ci_dataa", bus.ci_dataa, pair[63:32]);
                  checkOutput("ci_datab", bus.ci_datab, pair[31:0]);
               end
               prod = bus.ci_dataa * bus.ci_datab;
               acc  = (macElems == 0) ? prod : acc + prod;
               macElems++;
               if (macElems == curK) begin
                  macQ.push_back(acc);
                  macElems = 0;
                  if (macQ.size() > macMax) macMax = macQ.size();
               end
            end else if (bus.ci_n == OP_END) begin
               endCnt++;
               endCyc = cyc;
               if (endCnt == 1) startsBeforeFirstEnd = startCnt;
               checkOutput("END operands", bus.ci_dataa | bus.ci_datab, 32'd0);
               if (macQ.size() == 0) begin
                  checkOutput("END with no dot product", 32'd0, 32'd1);
               end else begin
                  doneVal = macQ.pop_front();
                  if (!suppressDone) doneCnt = 2;
               end
            end else if (bus.ci_n == OP_RESET) begin
               resetCnt++;
               resetCyc = cyc;
               macQ.delete();
               macElems = 0;
            end else begin
               checkOutput("illegal opcode", 32'(bus.ci_n), 32'(OP_START));
            end
         end
      end
   end

   // Scoreboard drain: a result is taken on every res_valid && res_ready edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && bus.res_valid && bus.res_ready) begin
            resCnt++;
            if (expQ.size() == 0) checkOutput("result with empty scoreboard", 32'd1, 32'd0);
            else checkOutput("res_data", bus.res_data, expQ.pop_front());
         end
      end
   end

   task automatic sendCmd(input int k, input int cnt, output bit ok);
      @(negedge clk);
      curK = k;
      macElems = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_k     = 8'(k);
      bus.cmd_cnt   = 8'(cnt);
      ok = 1'b0;
      for (int t = 0; t < 600; t++) begin
         #1;
         if (bus.cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (!ok) checkOutput("command accept timeout", 32'd0, 32'd1);
   endtask

   task automatic driveOp(input logic [31:0] a, input logic [31:0] b, output bit ok);
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      ok = 1'b0;
      for (int t = 0; t < 600; t++) begin
         #1;
         if (bus.op_ready) begin
            opQ.push_back({a, b});
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) checkOutput("operand accept timeout", 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input int k, input int cnt, input bit useRandom);
      logic [31:0] a, b, sum;
      int seq = 0;
      bit ok;
      sendCmd(k, cnt, ok);
      if (!ok) return;
      for (int d = 0; d < cnt; d++) begin
         sum = 32'd0;
         for (int e = 0; e < k; e++) begin
            if (useRandom) begin
               a = $urandom;
               b = $urandom_range(0, 65535);
            end else begin
               a = 32'(2 * seq + 1);
               b = 32'(2 * seq + 2);
            end
            seq++;
            sum = sum + a * b;
            if (e == k - 1) expQ.push_back(sum);
            driveOp(a, b, ok);
            if (!ok) begin
               bus.op_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      for (int t = 0; t < 800; t++) begin
         @(negedge clk);
         #1;
         if (!bus.busy) break;
      end
      checkOutput(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] expOps[4];
      bit ok;
      bit seen;
      int r0, sz;
      bus.cmd_valid = 1'b0;
      bus.cmd_k     = 8'd0;
      bus.cmd_cnt   = 8'd0;
      bus.op_valid  = 1'b0;
      bus.op_a      = 32'd0;
      bus.op_b      = 32'd0;
      bus.res_ready = 1'b1;

      #2;
      checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset ci_start", 32'(bus.ci_start), 32'd0);
      checkOutput("reset res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("reset err", 32'(bus.err), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);

      $display("[TB] k=3 cnt=1 single dot product");
      opLog.delete();
      applyStimulus(3, 1, 1'b0);
      waitIdle("t1 busy drops");
      expOps = '{OP_START, OP_NEXT, OP_NEXT, OP_END};
      checkOutput("t1 opcode count", 32'(opLog.size()), 32'd4);
      for (int i = 0; i < 4 && i < opLog.size(); i++)
         checkOutput("t1 opcode", 32'(opLog[i]), 32'(expOps[i]));
      checkOutput("t1 scoreboard empty", 32'(expQ.size()), 32'd0);

      $display("[TB] k=1 cnt=6 against OUTSTANDING");
      startCnt = 0; endCnt = 0; macMax = 0; r0 = resCnt;
      applyStimulus(1, 6, 1'b1);
      waitIdle("t2 busy drops");
      checkOutput("t2 STARTs before first END", 32'(startsBeforeFirstEnd), 32'(OUTS));
      checkOutput("t2 peak outstanding", 32'(macMax), 32'(OUTS));
      checkOutput("t2 result count", 32'(resCnt - r0), 32'd6);
      checkOutput("t2 scoreboard empty", 32'(expQ.size()), 32'd0);

      $display("[TB] result back-pressure on 2-dot command");
      endCnt = 0;
      bus.res_ready = 1'b0;
      applyStimulus(2, 2, 1'b1);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus.res_valid) break;
      end
      repeat (10) @(negedge clk);
      checkOutput("t3 END withheld", 32'(endCnt), 32'd1);
      checkOutput("t3 res_valid held", 32'(bus.res_valid), 32'd1);
      checkOutput("t3 res_data held", bus.res_data, (expQ.size() > 0) ? expQ[0] : 32'hFFFF_FFFF);
      bus.res_ready = 1'b1;
      waitIdle("t3 busy drops");
      checkOutput("t3 second END", 32'(endCnt), 32'd2);
      checkOutput("t3 scoreboard empty", 32'(expQ.size()), 32'd0);

      $display("[TB] zero-length commands");
      for (int i = 0; i < 2; i++) begin
         applyStimulus((i == 0) ? 0 : 2, (i == 0) ? 3 : 0, 1'b1);
         #1;
         checkOutput("bad cmd err", 32'(bus.err), 32'd1);
         checkOutput("bad cmd cmd_ready", 32'(bus.cmd_ready), 32'd1);
         checkOutput("bad cmd busy", 32'(bus.busy), 32'd0);
         bus.op_valid = 1'b1;
         seen = 1'b0;
         repeat (4) begin
            @(negedge clk);
            #1;
            seen = seen | bus.op_ready;
         end
         bus.op_valid = 1'b0;
         checkOutput("bad cmd op_ready", 32'(seen), 32'd0);
      end

      $display("[TB] watchdog expiry");
      suppressDone = 1'b1;
      resetCnt = 0; endCnt = 0;
      applyStimulus(1, 1, 1'b1);
      checkOutput("good cmd clears err", 32'(bus.err), 32'd0);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         #3;
         if (resetCnt > 0) break;
      end
      checkOutput("timeout RESET pulses", 32'(resetCnt), 32'd1);
      checkOutput("timeout END-to-RESET cycles", 32'(resetCyc - endCyc), 32'(TMO));
      checkOutput("timeout err", 32'(bus.err), 32'd1);
      checkOutput("timeout busy", 32'(bus.busy), 32'd0);
      checkOutput("timeout cmd_ready", 32'(bus.cmd_ready), 32'd1);
      expQ.delete();
      suppressDone = 1'b0;
      applyStimulus(2, 1, 1'b1);
      checkOutput("recovery clears err", 32'(bus.err), 32'd0);
      waitIdle("recovery busy drops");
      checkOutput("recovery scoreboard empty", 32'(expQ.size()), 32'd0);

      $display("[TB] reset while waiting for END result");
      suppressDone = 1'b1;
      endCnt = 0; resetCnt = 0;
      applyStimulus(1, 1, 1'b1);
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         #3;
         if (endCnt > 0) break;
      end
      checkOutput("rst END seen", 32'(endCnt), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rst ci_start", 32'(bus.ci_start), 32'd0);
      checkOutput("rst ci_n", 32'(bus.ci_n), 32'd0);
      checkOutput("rst busy", 32'(bus.busy), 32'd0);
      checkOutput("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("rst op_ready", 32'(bus.op_ready), 32'd0);
      checkOutput("rst res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst err", 32'(bus.err), 32'd0);
      sz = opLog.size();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      expQ.delete(); opQ.delete(); macQ.delete();
      doneCnt = 0; macElems = 0; suppressDone = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst no ci_start", 32'(opLog.size() - sz), 32'd0);
      checkOutput("rst no RESET opcode", 32'(resetCnt), 32'd0);
      checkOutput("rst release cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("rst release busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] bench did not complete");
   end

endmodule
